// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pkg
// Description : Shared state encoding, board-size defaults and row helpers
//               for the Tetris game controller.
// Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_GEN   = 3'b001,
        ST_MOVE  = 3'b010,
        ST_LAND  = 3'b011,
        ST_CLEAR = 3'b100,
        ST_OVER  = 3'b101,
        ST_PAUSE = 3'b110
    } state_t;

    localparam int C_DEF_ROWS  = 11;
    localparam int C_DEF_ROW_W = 4;
    localparam int C_MAX_ROWS  = 32;

    // Index of the highest set bit; 0 when the mask is empty.
    function automatic int highest_set(input logic [C_MAX_ROWS-1:0] mask);
        int idx;
        idx = 0;
        for (int i = 0; i < C_MAX_ROWS; i++) begin
            if (mask[i]) idx = i;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/drop_timer.sv
`default_nettype none
// ============================================================================
// Module      : drop_timer
// Description : Gravity counter; pulses tick on the last count of each period.
// Revision    : 1.0 - initial release
// ============================================================================
module drop_timer #(
    parameter int TICK_W = 16
) (
    input  logic              clka,
    input  logic              restart_n,
    input  logic              clr,
    input  logic              en,
    input  logic [TICK_W-1:0] period,
    output logic              tick
);

    logic [TICK_W-1:0] r_count;
    logic              w_last;

    // >= keeps the counter from running away if the period ever shrinks mid-count.
    assign w_last = (r_count >= period - TICK_W'(1));
    assign tick   = en && w_last;

    always_ff @(posedge clka) begin
        if (!restart_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_last ? '0 : r_count + TICK_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : game_ctrl_fsm
// Description : Top-level Tetris sequencer: GEN/MOVE/LAND/CLEAR handshakes,
//               gravity timing, row-clear ordering, scoring, pause, game over.
// Revision    : 1.0 - initial release
// ============================================================================
module game_ctrl_fsm
    import tetris_pkg::*;
#(
    parameter int ROWS            = C_DEF_ROWS,
    parameter int ROW_W           = C_DEF_ROW_W,
    parameter int TICK_BASE       = 1000,
    parameter int TICK_STEP       = 50,
    parameter int TICK_MIN        = 100,
    parameter int TICK_W          = 16,
    parameter int LINES_PER_LEVEL = 10,
    parameter int LVL_W           = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clka,
    input  logic             restart_n,
    input  logic             start_game,
    input  logic             pause,
    input  logic             touched,
    input  logic             gen_done,
    input  logic             spawn_blocked,
    input  logic             land_done,
    input  logic [ROWS-1:0]  full_rows,
    input  logic             clear_done,
    output logic [2:0]       state,
    output logic             start_gen,
    output logic             start_move,
    output logic             start_land,
    output logic             start_clear,
    output logic             drop_tick,
    output logic [ROW_W-1:0] clear_row,
    output logic [CNT_W-1:0] lines,
    output logic [LVL_W-1:0] level,
    output logic             game_over
);

    localparam int C_PW    = TICK_W + LVL_W;
    localparam int C_SUB_W = $clog2(LINES_PER_LEVEL + 1);

    state_t             r_state, w_state_n;
    logic               r_start_gen, r_start_move, r_start_land, r_start_clear;
    logic               w_start_gen_n, w_start_move_n, w_start_land_n, w_start_clear_n;
    logic [ROWS-1:0]    r_mask, w_mask_n;
    logic [CNT_W-1:0]   r_lines, w_lines_n;
    logic [LVL_W-1:0]   r_level, w_level_n;
    logic [C_SUB_W-1:0] r_sub, w_sub_n;
    logic [C_PW-1:0]    w_dec;
    logic [TICK_W-1:0]  w_period;
    logic               w_tick;
    int                 w_hi;

    // Wide arithmetic so level*step never wraps before the floor is applied.
    assign w_dec    = C_PW'(r_level) * C_PW'(TICK_STEP);
    assign w_period = (C_PW'(TICK_BASE) > C_PW'(TICK_MIN) + w_dec)
                    ? TICK_W'(C_PW'(TICK_BASE) - w_dec) : TICK_W'(TICK_MIN);

    drop_timer #(
        .TICK_W (TICK_W)
    ) u_drop_timer (
        .clka      (clka),
        .restart_n (restart_n),
        .clr       ((r_state != ST_MOVE) && (r_state != ST_PAUSE)),
        .en        (r_state == ST_MOVE),
        .period    (w_period),
        .tick      (w_tick)
    );

    // Clearing the topmost row first leaves the lower mask indices valid after the shift.
    assign w_hi = highest_set(C_MAX_ROWS'(r_mask));

    always_comb begin
        w_state_n       = r_state;
        w_start_gen_n   = 1'b0;
        w_start_move_n  = 1'b0;
        w_start_land_n  = 1'b0;
        w_start_clear_n = 1'b0;
        w_mask_n        = r_mask;
        w_lines_n       = r_lines;
        w_level_n       = r_level;
        w_sub_n         = r_sub;
        case (r_state)
            ST_IDLE: begin
                if (start_game) begin
                    w_state_n     = ST_GEN;
                    w_start_gen_n = 1'b1;
                end
            end
            ST_GEN: begin
                if (gen_done) begin
                    if (spawn_blocked) begin
                        w_state_n = ST_OVER;
                    end else begin
                        w_state_n      = ST_MOVE;
                        w_start_move_n = 1'b1;
                    end
                end
            end
            ST_MOVE: begin
                if (w_tick) begin
                    if (touched) begin
                        w_state_n      = ST_LAND;
                        w_start_land_n = 1'b1;
                    end
                end else if (pause) begin
                    w_state_n = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (!pause) w_state_n = ST_MOVE;
            end
            ST_LAND: begin
                if (land_done) begin
                    w_mask_n = full_rows;
                    if (full_rows != '0) begin
                        w_state_n       = ST_CLEAR;
                        w_start_clear_n = 1'b1;
                    end else begin
                        w_state_n     = ST_GEN;
                        w_start_gen_n = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                if (clear_done) begin
                    w_mask_n = r_mask & ~(ROWS'(1) << w_hi);
                    if (r_lines != '1) w_lines_n = r_lines + CNT_W'(1);
                    if (r_sub >= C_SUB_W'(LINES_PER_LEVEL - 1)) begin
                        w_sub_n = '0;
                        if (r_level != '1) w_level_n = r_level + LVL_W'(1);
                    end else begin
                        w_sub_n = r_sub + C_SUB_W'(1);
                    end
                    if (w_mask_n != '0) begin
                        w_start_clear_n = 1'b1;
                    end else begin
                        w_state_n     = ST_GEN;
                        w_start_gen_n = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (start_game) begin
                    w_state_n     = ST_GEN;
                    w_start_gen_n = 1'b1;
                    w_lines_n     = '0;
                    w_level_n     = '0;
                    w_sub_n       = '0;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (!restart_n) begin
            r_state       <= ST_IDLE;
            r_start_gen   <= 1'b0;
            r_start_move  <= 1'b0;
            r_start_land  <= 1'b0;
            r_start_clear <= 1'b0;
            r_mask        <= '0;
            r_lines       <= '0;
            r_level       <= '0;
            r_sub         <= '0;
        end else begin
            r_state       <= w_state_n;
            r_start_gen   <= w_start_gen_n;
            r_start_move  <= w_start_move_n;
            r_start_land  <= w_start_land_n;
            r_start_clear <= w_start_clear_n;
            r_mask        <= w_mask_n;
            r_lines       <= w_lines_n;
            r_level       <= w_level_n;
            r_sub         <= w_sub_n;
        end
    end

    assign state       = r_state;
    assign start_gen   = r_start_gen;
    assign start_move  = r_start_move;
    assign start_land  = r_start_land;
    assign start_clear = r_start_clear;
    assign drop_tick   = w_tick;
    assign clear_row   = ROW_W'(w_hi);
    assign lines       = r_lines;
    assign level       = r_level;
    assign game_over   = (r_state == ST_OVER);

endmodule
`default_nettype wire

// File: doc/game_ctrl_fsm.md
Name: game_ctrl_fsm

Overview:
Parametrised top-level game controller for the Tetris chip, replacing the fixed five-state sequencer.
- Sequences GEN -> MOVE -> LAND -> CLEAR using start-pulse/done handshakes with each datapath stage.
- Owns the gravity drop timer, multi-row clear sequencing, the lines/level scoring counters, pause and game-over.
- Sits between the board datapath (gen/move/land/clear units) and the display/score logic.

Parameters:
ROWS, 11, board rows; row 0 is the bottom row.
ROW_W, 4, width of a row index; must satisfy 2^ROW_W >= ROWS.
TICK_BASE, 1000, drop period in clka cycles at level 0.
TICK_STEP, 50, drop period reduction per level.
TICK_MIN, 100, floor on the drop period.
TICK_W, 16, drop counter width.
LINES_PER_LEVEL, 10, cleared lines per level increment.
LVL_W, 4, level width.
CNT_W, 16, lines counter width.

Ports:
clka  in  1  system clock; all logic on posedge.
restart_n  in  1  synchronous active-low reset.
start_game  in  1  starts a game from IDLE or OVER.
pause  in  1  level-sensitive pause request.
touched  in  1  from move unit: piece cannot descend further.
gen_done  in  1  1-cycle pulse: piece generation finished.
spawn_blocked  in  1  qualified by gen_done: spawn location occupied.
land_done  in  1  1-cycle pulse: piece written into board.
full_rows  in  ROWS  bitmask of full rows, valid when land_done=1.
clear_done  in  1  1-cycle pulse: requested row removed, rows above shifted down.
state  out  3  current state encoding.
start_gen, start_move, start_land, start_clear  out  1 each  1-cycle start pulses.
drop_tick  out  1  1-cycle gravity pulse to the move unit.
clear_row  out  ROW_W  index of the row to clear; valid while start_clear=1.
lines  out  CNT_W  total lines cleared.
level  out  LVL_W  current level.
game_over  out  1  high while in OVER.

Behaviour:
- State encodings: IDLE=000, GEN=001, MOVE=010, LAND=011, CLEAR=100, OVER=101, PAUSE=110. Any other value goes to IDLE on the next cycle.
- Reset (restart_n=0 at posedge): state=IDLE and every output 0, including lines, level, the drop counter and the clear mask. Reset overrides every other input in any state, including mid-clear.
- start_X pulses are registered and asserted exactly in the first cycle that state==X. Re-entry from PAUSE to MOVE issues no start_move.
- IDLE: on start_game -> GEN.
- GEN: wait for gen_done.
  - gen_done=1 and spawn_blocked=1 -> OVER.
  - gen_done=1 and spawn_blocked=0 -> MOVE.
- MOVE (drop timer):
  - Counter is cleared on entry and counts 0..P-1.
  - drop_tick is asserted when counter==P-1; the counter then wraps to 0.
  - Period P = max(TICK_MIN, TICK_BASE - level*TICK_STEP). Compute in TICK_W+LVL_W bits so the subtraction cannot underflow.
  - touched=1 in the same cycle as drop_tick -> LAND (lock on tick only). touched without a tick is ignored.
  - pause=1 with no tick -> PAUSE. If a tick and pause coincide, the tick is serviced first and pause is taken on the next cycle.
- PAUSE: drop counter frozen; drop_tick=0. pause=0 -> MOVE, resuming the same count.
- LAND: wait for land_done.
  - Latch full_rows into the clear mask.
  - Mask zero -> GEN; nonzero -> CLEAR.
- CLEAR:
  - clear_row = highest set index in the mask. Top-first order keeps the lower indices valid after each shift.
  - On clear_done: remove that bit, increment lines (saturating) and increment the per-level sub-counter.
  - When the sub-counter reaches LINES_PER_LEVEL it resets to 0 and level increments, saturating at 2^LVL_W-1.
  - Mask still nonzero -> re-enter CLEAR with a new start_clear pulse, one cycle later. Mask empty -> GEN.
- OVER: game_over=1. start_game -> GEN and, in the same edge, clears lines, level and the sub-counter.
- Signals with no effect in the current state:
  - done signals and touched outside their owning state;
  - start_game outside IDLE/OVER;
  - pause outside MOVE/PAUSE.
- The controller has no internal timeouts; it waits indefinitely for done pulses.

Decomposition:
- Package tetris_pkg holds: state encoding localparams, ROWS/ROW_W defaults, and a highest-set-bit priority-encode function.
- Sub-module drop_timer holds the drop counter.
  - Inputs: clka, restart_n, clr, en, period.
  - Output: tick.

Test Plan:
Params for all scenarios: TICK_BASE=8, TICK_STEP=2, TICK_MIN=4, LINES_PER_LEVEL=2, ROWS=11.
1. Basic loop: reset, start_game, gen_done -> start_gen then start_move pulses; drop_tick every 8 cycles; touched on the 2nd tick -> LAND; land_done with full_rows=0 -> GEN.
2. Multi-clear: land_done with full_rows=11'b000_0010_0100 -> start_clear with clear_row=5, then clear_row=2 after the second clear_done; lines=2, level=1, then GEN.
3. Level speed-up: drive lines to 6 -> level=3, drop period = max(4, 8-6) = 4. Level saturates at 15 and the period stays at 4.
4. Pause: pause asserted at counter=3 for 20 cycles -> no drop_tick, state=PAUSE; after release the next tick arrives 4 cycles later and there is no start_move.
5. Game over: gen_done with spawn_blocked=1 -> OVER, game_over=1. start_game -> GEN with lines=0, level=0.
6. Reset mid-operation: restart_n=0 during CLEAR with a 2-row mask -> IDLE next cycle, mask cleared, all outputs 0; a stray clear_done afterwards has no effect.
